if_prefetch: RTL
================

Name: if_prefetch

Overview:
Instruction prefetch unit that sits directly upstream of the instruction port of the unified testbench memory/arbiter. It issues sequential word fetches using the req/gnt/valid protocol and tracks outstanding requests. Returned words are buffered in a small FIFO that feeds the decode stage over a valid/ready handshake. Branch redirects flush the FIFO and discard in-flight responses.

Parameters:
FIFO_DEPTH, 4, number of instruction entries buffered (power of two, >=2)
MAX_OUTSTANDING, 2, max granted-but-unreturned requests
RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)

Ports:
clk  input  1  clock; all state on rising edge
reset_n  input  1  asynchronous active-low reset
fetch_en  input  1  permits new requests; outstanding ones complete regardless
branch_valid  input  1  redirect strobe, one cycle
branch_addr  input  32  redirect target; bits[1:0] ignored, forced 0
instr_req  output  1  fetch request to memory
instr_addr  output  32  fetch address, word aligned
instr_gnt  input  1  request accepted this cycle
instr_rdata  input  32  returned word, qualified by instr_valid
instr_err  input  1  bus error, qualified by instr_valid
instr_valid  input  1  response strobe, in order, one cycle after gnt
out_valid  output  1  FIFO head valid to decode
out_ready  input  1  decode accepts head
out_instr  output  32  head instruction word
out_pc  output  32  head instruction address
out_err  output  1  head carried bus error
busy  output  1  outstanding requests non-zero or instr_req high

Behaviour:
- Reset: instr_req=0, instr_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, out_err=0, busy=0; FIFO empty, outstanding=0, discard=0, next fetch PC=RESET_PC.
- Issue condition: fetch_en & outstanding<MAX_OUTSTANDING & (fifo_count+outstanding-discard)<FIFO_DEPTH. When met, instr_req rises with instr_addr=fetch PC. No combinational path from instr_gnt to instr_req.
- Once raised, instr_req and instr_addr hold stable until instr_gnt, even if fetch_en falls or a branch arrives.
- On req&gnt: outstanding+1; fetch PC+4 (wraps 32'hFFFF_FFFC->0). A new request can issue next cycle, giving back-to-back fetches.
- On instr_valid: outstanding-1. If discard>0, decrement discard and drop the word. Otherwise push {rdata, err, pc} into the FIFO; pc comes from an internal return-address counter. A push never overflows because of the issue condition.
- FIFO is registered: a word returned in cycle N is visible on out_valid in N+1. Pop on out_valid&out_ready. Push and pop in the same cycle when full is legal.
- Branch (branch_valid=1), all in the same cycle:
  - FIFO flushed; out_valid=0 next cycle.
  - discard = outstanding after this cycle's gnt/valid updates. A response arriving this cycle is dropped; a request granted this cycle is discarded.
  - An ungranted pending request stays asserted until granted; it is counted into discard at its grant.
  - fetch PC = branch_addr & ~3.
  - Latency: branch in cycle N with no pending request gives instr_req for the target in N+1.
- Branch while another redirect's discards are pending: the latest target wins; discards accumulate correctly.
- instr_err entries are passed through with out_err=1. The prefetcher keeps fetching sequentially; decode decides the action.
- fetch_en low: no new requests; outstanding responses still land in the FIFO; fetch PC is held.
- Reset mid-operation returns all state to reset values immediately; late memory responses after reset are not expected.

Test Plan:
- Reset release, fetch_en=1, memory always grants: instr_addr 0,4,8,12 on consecutive cycles; out_pc 0,4,8 on consecutive cycles with matching out_instr; outstanding never exceeds 2.
- out_ready=0 with FIFO_DEPTH=4: after 4 words are buffered plus in-flight returns, instr_req stays 0 and the FIFO holds pcs 0..12. Raising out_ready resumes fetch at 16.
- branch_valid with target 32'h0000_0103 in the same cycle as instr_valid for pc 8 and gnt for pc 12: both words dropped, FIFO flushed; next instr_addr=32'h100; first out_pc=32'h100.
- Memory withholds gnt for 3 cycles on pc 4 while a branch to 0x200 arrives: instr_addr stays 4 until granted; that word is discarded; then fetch 0x200.
- instr_err=1 returned for pc 8: out_err=1 with out_pc=8; the next entry pc 12 has out_err=0.
- fetch_en dropped with 2 outstanding: both words delivered; no further instr_req; busy falls to 0 after the last instr_valid.

Source files
------------

// File: rtl/if_prefetch.sv
// Sequential instruction prefetcher: issues word fetches over req/gnt/valid, buffers returns
// in a registered FIFO for decode, and discards in-flight responses across branch redirects.
module if_prefetch #(
   parameter int unsigned FIFO_DEPTH      = 4,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        fetch_en,
   input  logic        branch_valid,
   input  logic [31:0] branch_addr,
   output logic        instr_req,
   output logic [31:0] instr_addr,
   input  logic        instr_gnt,
   input  logic [31:0] instr_rdata,
   input  logic        instr_err,
   input  logic        instr_valid,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        out_err,
   output logic        busy
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        err;
   } entry_t;

   logic          req_q, req_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   pc_q, pc_d;          // next address to request
   logic [31:0]   ret_pc_q, ret_pc_d;  // address of the next kept response
   logic [OW-1:0] out_q, out_d;
   logic [OW-1:0] disc_q, disc_d;
   logic          stale_q, stale_d;    // pending request predates the latest redirect
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
   entry_t        mem_q [FIFO_DEPTH];

   logic        gnt_acc, push, pop, issue;
   logic [31:0] target;

   always_comb begin
      gnt_acc = req_q & instr_gnt;
      target  = {branch_addr[31:2], 2'b00};
      push    = instr_valid & ~branch_valid & (disc_q == '0);
      pop     = out_valid & out_ready;
      out_d   = OW'(32'(out_q) + 32'(gnt_acc) - 32'(instr_valid));
      if (branch_valid) begin
         // everything still in flight after this cycle belongs to the old stream
         disc_d   = out_d;
         stale_d  = req_q & ~instr_gnt;
         pc_d     = target;
         ret_pc_d = target;
         cnt_d    = '0;
         rd_d     = '0;
         wr_d     = '0;
      end else begin
         disc_d = disc_q;
         if (instr_valid && disc_q != '0) disc_d = disc_d - OW'(1);
         if (gnt_acc && stale_q) disc_d = disc_d + OW'(1);
         stale_d  = stale_q & ~gnt_acc;
         pc_d     = (gnt_acc && !stale_q) ? pc_q + 32'd4 : pc_q;
         ret_pc_d = push ? ret_pc_q + 32'd4 : ret_pc_q;
         cnt_d    = CW'(32'(cnt_q) + 32'(push) - 32'(pop));
         rd_d     = rd_q + AW'(pop);
         wr_d     = wr_q + AW'(push);
      end
      // reserve FIFO room for every response that will actually be kept
      issue = fetch_en && (32'(out_d) < MAX_OUTSTANDING)
              && (32'(cnt_d) + 32'(out_d) - 32'(disc_d) < FIFO_DEPTH);
      if (req_q && !instr_gnt) begin
         req_d  = 1'b1;
         addr_d = addr_q;
      end else begin
         req_d  = issue;
         addr_d = issue ? pc_d : addr_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         req_q    <= 1'b0;
         addr_q   <= RESET_PC;
         pc_q     <= RESET_PC;
         ret_pc_q <= RESET_PC;
         out_q    <= '0;
         disc_q   <= '0;
         stale_q  <= 1'b0;
         cnt_q    <= '0;
         rd_q     <= '0;
         wr_q     <= '0;
      end else begin
         req_q    <= req_d;
         addr_q   <= addr_d;
         pc_q     <= pc_d;
         ret_pc_q <= ret_pc_d;
         out_q    <= out_d;
         disc_q   <= disc_d;
         stale_q  <= stale_d;
         cnt_q    <= cnt_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= {instr_rdata, ret_pc_q, instr_err};
   end

   assign instr_req  = req_q;
   assign instr_addr = addr_q;
   assign out_valid  = (cnt_q != '0);
   assign out_instr  = out_valid ? mem_q[rd_q].instr : 32'h0;
   assign out_pc     = out_valid ? mem_q[rd_q].pc : 32'h0;
   assign out_err    = out_valid & mem_q[rd_q].err;
   assign busy       = req_q | (out_q != '0);

endmodule
